// File: rtl/pattern_sequencer_if.sv
`default_nettype none
// ----------------------------------------------------------------------------
// pattern_sequencer_if - timing/generator/display signal bundle for the sequencer
// Rev 1.0
// ----------------------------------------------------------------------------
interface pattern_sequencer_if #(
    parameter int NUM_PATTERNS = 3
) ();
    localparam int SEL_W = (NUM_PATTERNS > 1) ? $clog2(NUM_PATTERNS) : 1;

    logic                      vsync;
    logic                      paused;
    logic                      mode_auto;
    logic                      btn_next;
    logic [6*NUM_PATTERNS-1:0] pattern_rgb;
    logic [5:0]                rgb;
    logic [SEL_W-1:0]          pattern_sel;
    logic [NUM_PATTERNS-1:0]   next_frame;
    logic [NUM_PATTERNS-1:0]   pattern_rst;
    logic                      busy;

    modport master (
        output vsync, paused, mode_auto, btn_next, pattern_rgb,
        input  rgb, pattern_sel, next_frame, pattern_rst, busy
    );

    modport slave (
        input  vsync, paused, mode_auto, btn_next, pattern_rgb,
        output rgb, pattern_sel, next_frame, pattern_rst, busy
    );
endinterface
`default_nettype wire

// File: rtl/pattern_sequencer.sv
`default_nettype none
// ----------------------------------------------------------------------------
// pattern_sequencer - cycles NUM_PATTERNS generators, auto or manual, with optional fade
// Rev 1.0
// ----------------------------------------------------------------------------
module pattern_sequencer #(
    parameter int NUM_PATTERNS       = 3,
    parameter int FRAMES_PER_PATTERN = 300,
    parameter int FADE_STEP_FRAMES   = 4
) (
    input  wire logic          clk,
    input  wire logic          rst,
    pattern_sequencer_if.slave bus
);
    localparam int SEL_W  = $clog2(NUM_PATTERNS);
    localparam int FRM_W  = $clog2(FRAMES_PER_PATTERN);
    localparam int STEP_W = (FADE_STEP_FRAMES > 1) ? $clog2(FADE_STEP_FRAMES) : 1;

    localparam logic [SEL_W-1:0]        LAST_SEL   = SEL_W'(NUM_PATTERNS - 1);
    localparam logic [FRM_W-1:0]        LAST_FRAME = FRM_W'(FRAMES_PER_PATTERN - 1);
    localparam logic [STEP_W-1:0]       LAST_STEP  =
        STEP_W'((FADE_STEP_FRAMES > 0) ? FADE_STEP_FRAMES - 1 : 0);
    localparam logic [NUM_PATTERNS-1:0] ONE_HOT0   = NUM_PATTERNS'(1);

    typedef enum logic [1:0] {
        SHOW     = 2'd0,
        FADE_OUT = 2'd1,
        FADE_IN  = 2'd2
    } state_t;

    state_t                  state_q;
    logic [SEL_W-1:0]        sel_q;
    logic [FRM_W-1:0]        frame_cnt_q;
    logic [STEP_W-1:0]       step_cnt_q;
    logic [1:0]              fade_level_q;
    logic                    vsync_q;
    logic [NUM_PATTERNS-1:0] pattern_rst_q;

    logic                    tick;
    logic                    anim_tick;
    logic                    switch_req;
    logic                    step_done;
    logic [SEL_W-1:0]        next_sel;
    logic [5:0]              pix;

    assign tick       = bus.vsync & ~vsync_q;
    assign anim_tick  = tick & ~bus.paused;
    assign switch_req = bus.btn_next |
                        (bus.mode_auto & anim_tick & (frame_cnt_q == LAST_FRAME));
    assign step_done  = (step_cnt_q == LAST_STEP);
    assign next_sel   = (sel_q == LAST_SEL) ? '0 : sel_q + SEL_W'(1);

    function automatic logic [1:0] dim(input logic [1:0] c, input logic [1:0] lvl);
        return (c > lvl) ? c - lvl : 2'd0;
    endfunction

    always_comb begin
        pix = bus.pattern_rgb[5:0];
        for (int i = 0; i < NUM_PATTERNS; i++) begin
            if (sel_q == SEL_W'(i)) pix = bus.pattern_rgb[6*i +: 6];
        end
    end

    assign bus.rgb         = {dim(pix[5:4], fade_level_q),
                              dim(pix[3:2], fade_level_q),
                              dim(pix[1:0], fade_level_q)};
    assign bus.pattern_sel = sel_q;
    assign bus.next_frame  = anim_tick ? (ONE_HOT0 << sel_q) : '0;
    // Reset level is held on every generator for as long as rst is asserted.
    assign bus.pattern_rst = rst ? '1 : pattern_rst_q;
    assign bus.busy        = (state_q != SHOW);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= SHOW;
            sel_q         <= '0;
            frame_cnt_q   <= '0;
            step_cnt_q    <= '0;
            fade_level_q  <= 2'd0;
            vsync_q       <= 1'b1;
            pattern_rst_q <= '0;
        end else begin
            vsync_q       <= bus.vsync;
            pattern_rst_q <= '0;
            case (state_q)
                SHOW: begin
                    if (switch_req) begin
                        if (FADE_STEP_FRAMES == 0) begin
                            sel_q         <= next_sel;
                            frame_cnt_q   <= '0;
                            pattern_rst_q <= ONE_HOT0 << next_sel;
                        end else begin
                            state_q      <= FADE_OUT;
                            step_cnt_q   <= '0;
                            fade_level_q <= 2'd0;
                        end
                    end else if (anim_tick & bus.mode_auto) begin
                        frame_cnt_q <= frame_cnt_q + FRM_W'(1);
                    end
                end
                FADE_OUT: begin
                    if (tick) begin
                        if (step_done) begin
                            step_cnt_q <= '0;
                            if (fade_level_q == 2'd3) begin
                                state_q       <= FADE_IN;
                                sel_q         <= next_sel;
                                frame_cnt_q   <= '0;
                                pattern_rst_q <= ONE_HOT0 << next_sel;
                            end else begin
                                fade_level_q <= fade_level_q + 2'd1;
                            end
                        end else begin
                            step_cnt_q <= step_cnt_q + STEP_W'(1);
                        end
                    end
                end
                FADE_IN: begin
                    if (tick) begin
                        if (step_done) begin
                            step_cnt_q <= '0;
                            // Reaching level 0 completes the fade-in.
                            if (fade_level_q <= 2'd1) begin
                                state_q      <= SHOW;
                                fade_level_q <= 2'd0;
                            end else begin
                                fade_level_q <= fade_level_q - 2'd1;
                            end
                        end else begin
                            step_cnt_q <= step_cnt_q + STEP_W'(1);
                        end
                    end
                end
                default: state_q <= SHOW;
            endcase
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_pattern_sequencer.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_pattern_sequencer - two sequencers (fade step 2 and instant switch) against a frame-level model
// Rev 1.0
// ----------------------------------------------------------------------------
module tb_pattern_sequencer;
    localparam int N   = 3;
    localparam int FPP = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          vsync = 1'b1;
    logic          paused = 1'b0;
    logic          mode_auto = 1'b0;
    logic          btn_next = 1'b0;
    logic [6*N-1:0] prgb = '0;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    pattern_sequencer_if #(.NUM_PATTERNS(N)) ifa ();
    pattern_sequencer_if #(.NUM_PATTERNS(N)) ifb ();

    assign ifa.vsync = vsync;  assign ifa.paused = paused;  assign ifa.mode_auto = mode_auto;
    assign ifa.btn_next = btn_next;  assign ifa.pattern_rgb = prgb;
    assign ifb.vsync = vsync;  assign ifb.paused = paused;  assign ifb.mode_auto = mode_auto;
    assign ifb.btn_next = btn_next;  assign ifb.pattern_rgb = prgb;

    pattern_sequencer #(.NUM_PATTERNS(N), .FRAMES_PER_PATTERN(FPP), .FADE_STEP_FRAMES(2)) u_fade (
        .clk(clk), .rst(rst), .bus(ifa.slave));
    pattern_sequencer #(.NUM_PATTERNS(N), .FRAMES_PER_PATTERN(FPP), .FADE_STEP_FRAMES(0)) u_inst (
        .clk(clk), .rst(rst), .bus(ifb.slave));

    // Frame-level model: a fade is just a count t of frame ticks since the request;
    // level = t/F while fading out, the switch lands at t=4F, level = 3-(t-4F)/F until t=7F.
    int         fade_f [2] = '{2, 0};
    int         m_sel [2];
    int         m_frame [2];
    int         m_t [2];
    bit         m_fading [2];
    logic [N-1:0] m_prst [2];
    bit         m_vs_prev;

    function automatic void model_reset();
        for (int k = 0; k < 2; k++) begin
            m_sel[k] = 0; m_frame[k] = 0; m_t[k] = 0; m_fading[k] = 0; m_prst[k] = '0;
        end
        m_vs_prev = 1'b1;
    endfunction

    function automatic int m_level(int k);
        int f = fade_f[k];
        if (!m_fading[k]) return 0;
        if (m_t[k] < 4*f) return m_t[k] / f;
        return 3 - (m_t[k] - 4*f) / f;
    endfunction

    function automatic logic [5:0] exp_rgb(int k);
        logic [5:0] pix;
        logic [5:0] r;
        int l;
        int v;
        pix = prgb[6*m_sel[k] +: 6];
        l = m_level(k);
        r = '0;
        for (int c = 0; c < 3; c++) begin
            v = int'(pix[2*c +: 2]);
            r[2*c +: 2] = (v > l) ? 2'(v - l) : 2'd0;
        end
        return r;
    endfunction

    function automatic logic [14:0] exp_vec(int k);
        logic [N-1:0] nf;
        nf = (vsync && !m_vs_prev && !paused) ? N'(1 << m_sel[k]) : '0;
        return {exp_rgb(k), 2'(m_sel[k]), nf, m_prst[k], m_fading[k]};
    endfunction

    function automatic logic [14:0] obs(int k);
        if (k == 0) return {ifa.rgb, ifa.pattern_sel, ifa.next_frame, ifa.pattern_rst, ifa.busy};
        return {ifb.rgb, ifb.pattern_sel, ifb.next_frame, ifb.pattern_rst, ifb.busy};
    endfunction

    function automatic void m_switch(int k);
        m_sel[k]   = (m_sel[k] == N-1) ? 0 : m_sel[k] + 1;
        m_frame[k] = 0;
        m_prst[k]  = N'(1 << m_sel[k]);
    endfunction

    task automatic step();
        bit tick;
        tick = vsync && !m_vs_prev;
        for (int k = 0; k < 2; k++) begin
            m_prst[k] = '0;
            if (!m_fading[k]) begin
                if (btn_next || (mode_auto && tick && !paused && m_frame[k] == FPP-1)) begin
                    if (fade_f[k] == 0) m_switch(k);
                    else begin m_fading[k] = 1; m_t[k] = 0; end
                end else if (mode_auto && tick && !paused) begin
                    m_frame[k]++;
                end
            end else if (tick) begin
                m_t[k]++;
                if (m_t[k] == 4*fade_f[k]) m_switch(k);
                if (m_t[k] == 7*fade_f[k]) m_fading[k] = 0;
            end
        end
        m_vs_prev = vsync;
        @(posedge clk);
        #1;
    endtask

    // Leaves the bench in the tick cycle (vsync just rose), before its clock edge.
    task automatic run_frame();
        int hi = $urandom_range(2, 0);
        int lo = $urandom_range(2, 1);
        vsync = 1'b1; repeat (hi) step();
        vsync = 1'b0; repeat (lo) step();
        vsync = 1'b1; #1;
    endtask

    task automatic press();
        btn_next = 1'b1; #1;
        step();
        btn_next = 1'b0;
    endtask

    task automatic wait_idle();
        for (int g = 0; g < 30 && m_fading[0]; g++) begin
            run_frame();
            step();
        end
    endtask

    task automatic test_reset();
        prgb = 18'($urandom);
        rst = 1'b1; #1;
        n_checks++;
        if ({ifa.rgb, ifa.pattern_sel, ifa.next_frame, ifa.pattern_rst, ifa.busy} !==
            {prgb[5:0], 2'd0, 3'b000, 3'b111, 1'b0}) begin
            n_fail++;
            $display("FAIL reset_a: got rgb=%h sel=%0d nf=%b prst=%b busy=%b, expected rgb=%h sel=0 nf=000 prst=111 busy=0",
                     ifa.rgb, ifa.pattern_sel, ifa.next_frame, ifa.pattern_rst, ifa.busy, prgb[5:0]);
        end
        n_checks++;
        if ({ifb.pattern_sel, ifb.pattern_rst, ifb.busy} !== {2'd0, 3'b111, 1'b0}) begin
            n_fail++;
            $display("FAIL reset_b: got sel=%0d prst=%b busy=%b, expected sel=0 prst=111 busy=0",
                     ifb.pattern_sel, ifb.pattern_rst, ifb.busy);
        end
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
        #1;
        for (int k = 0; k < 2; k++) begin
            n_checks++;
            if (obs(k) !== exp_vec(k)) begin
                n_fail++;
                $display("FAIL after_reset dut%0d: got %h expected %h", k, obs(k), exp_vec(k));
            end
        end
        step();
    endtask

    task automatic test_auto_cycle();
        mode_auto = 1'b1;
        for (int j = 1; j <= 18; j++) begin
            run_frame();
            for (int k = 0; k < 2; k++) begin
                n_checks++;
                if (obs(k) !== exp_vec(k)) begin
                    n_fail++;
                    $display("FAIL auto_tick dut%0d frame %0d: got %h expected %h", k, j, obs(k), exp_vec(k));
                end
            end
            step();
            for (int k = 0; k < 2; k++) begin
                n_checks++;
                if (obs(k) !== exp_vec(k)) begin
                    n_fail++;
                    $display("FAIL auto_post dut%0d frame %0d: got %h expected %h", k, j, obs(k), exp_vec(k));
                end
            end
            if (j == 4) begin
                n_checks++;
                if (ifa.busy !== 1'b1) begin
                    n_fail++; $display("FAIL auto_fade_start: got busy=%b expected 1", ifa.busy);
                end
            end
            if (j == 12) begin
                n_checks++;
                if ({ifa.pattern_sel, ifa.pattern_rst} !== {2'd1, 3'b010}) begin
                    n_fail++;
                    $display("FAIL auto_switch: got sel=%0d prst=%b expected sel=1 prst=010",
                             ifa.pattern_sel, ifa.pattern_rst);
                end
                step();
                n_checks++;
                if (ifa.pattern_rst !== 3'b000) begin
                    n_fail++; $display("FAIL auto_rst_pulse_len: got prst=%b expected 000", ifa.pattern_rst);
                end
            end
            if (j == 18) begin
                n_checks++;
                if (ifa.busy !== 1'b0) begin
                    n_fail++; $display("FAIL auto_fade_end: got busy=%b expected 0", ifa.busy);
                end
            end
        end
        mode_auto = 1'b0;
    endtask

    task automatic test_fade_levels();
        logic [5:0] tbl [14];
        tbl = '{6'h3F, 6'h2A, 6'h2A, 6'h15, 6'h15, 6'h00, 6'h00,
                6'h00, 6'h00, 6'h15, 6'h15, 6'h2A, 6'h2A, 6'h3F};
        prgb = '1;
        wait_idle();
        press();
        for (int j = 0; j < 14; j++) begin
            run_frame();
            step();
            n_checks++;
            if (ifa.rgb !== tbl[j]) begin
                n_fail++; $display("FAIL fade_level tick %0d: got rgb=%h expected %h", j+1, ifa.rgb, tbl[j]);
            end
            n_checks++;
            if (obs(0) !== exp_vec(0)) begin
                n_fail++; $display("FAIL fade_model tick %0d: got %h expected %h", j+1, obs(0), exp_vec(0));
            end
        end
        press();
        repeat (2) begin run_frame(); step(); end
        prgb = {3{6'b011001}};
        #1;
        n_checks++;
        if (ifa.rgb !== exp_rgb(0)) begin
            n_fail++; $display("FAIL fade_partial: got rgb=%h expected %h", ifa.rgb, exp_rgb(0));
        end
        wait_idle();
        prgb = 18'($urandom);
    endtask

    task automatic test_wrap();
        int rst0_cycles = 0;
        for (int g = 0; g < 3 && m_sel[0] != 2; g++) begin
            press();
            wait_idle();
        end
        press();
        for (int c = 0; c < 64; c++) begin
            vsync = (c % 4 < 2) ? 1'b0 : 1'b1;
            #1;
            for (int k = 0; k < 2; k++) begin
                n_checks++;
                if (obs(k) !== exp_vec(k)) begin
                    n_fail++; $display("FAIL wrap dut%0d cycle %0d: got %h expected %h", k, c, obs(k), exp_vec(k));
                end
            end
            n_checks++;
            if (ifa.pattern_rst[2:1] !== 2'b00) begin
                n_fail++; $display("FAIL wrap_other_rst cycle %0d: got prst=%b expected x00", c, ifa.pattern_rst);
            end
            if (ifa.pattern_rst[0] === 1'b1) rst0_cycles++;
            step();
        end
        n_checks++;
        if ({ifa.pattern_sel, ifa.busy} !== {2'd0, 1'b0} || rst0_cycles != 1) begin
            n_fail++;
            $display("FAIL wrap_end: got sel=%0d busy=%b rst0_cycles=%0d expected sel=0 busy=0 rst0_cycles=1",
                     ifa.pattern_sel, ifa.busy, rst0_cycles);
        end
        vsync = 1'b1;
        step();
    endtask

    task automatic test_paused();
        mode_auto = 1'b1;
        paused = 1'b1;
        for (int j = 0; j < 10; j++) begin
            run_frame();
            n_checks++;
            if ({ifa.next_frame, ifb.next_frame} !== 6'b0) begin
                n_fail++; $display("FAIL paused_nf: got %b/%b expected 000/000", ifa.next_frame, ifb.next_frame);
            end
            step();
        end
        paused = 1'b0;
        for (int g = 0; g < 8 && !m_fading[0]; g++) begin
            run_frame();
            for (int k = 0; k < 2; k++) begin
                n_checks++;
                if (obs(k) !== exp_vec(k)) begin
                    n_fail++; $display("FAIL unpaused dut%0d: got %h expected %h", k, obs(k), exp_vec(k));
                end
            end
            step();
        end
        n_checks++;
        if (ifa.busy !== 1'b1) begin
            n_fail++; $display("FAIL pause_fade_start: got busy=%b expected 1", ifa.busy);
        end
        repeat (3) begin run_frame(); step(); end
        paused = 1'b1;
        for (int g = 0; g < 20 && m_fading[0]; g++) begin
            run_frame();
            step();
            n_checks++;
            if (obs(0) !== exp_vec(0)) begin
                n_fail++; $display("FAIL paused_fade frame %0d: got %h expected %h", g, obs(0), exp_vec(0));
            end
        end
        n_checks++;
        if (ifa.busy !== 1'b0) begin
            n_fail++; $display("FAIL paused_fade_end: got busy=%b expected 0", ifa.busy);
        end
        paused = 1'b0;
        mode_auto = 1'b0;
    endtask

    task automatic test_back_to_back();
        int s0 = m_sel[0];
        int s1 = m_sel[1];
        press();
        n_checks++;
        if ({ifb.pattern_sel, ifb.busy, ifa.busy} !== {2'((s1 + 1) % N), 1'b0, 1'b1}) begin
            n_fail++;
            $display("FAIL instant_switch: got sel_b=%0d busy_b=%b busy_a=%b expected sel_b=%0d busy_b=0 busy_a=1",
                     ifb.pattern_sel, ifb.busy, ifa.busy, (s1 + 1) % N);
        end
        repeat (3) begin run_frame(); step(); end
        press();
        for (int g = 0; g < 30 && m_fading[0]; g++) begin
            run_frame();
            step();
            n_checks++;
            if (ifb.busy !== 1'b0) begin
                n_fail++; $display("FAIL instant_busy: got busy_b=%b expected 0", ifb.busy);
            end
        end
        n_checks++;
        if ({ifa.pattern_sel, ifb.pattern_sel, ifa.busy} !== {2'((s0 + 1) % N), 2'((s1 + 2) % N), 1'b0}) begin
            n_fail++;
            $display("FAIL b2b_switch: got sel_a=%0d sel_b=%0d busy_a=%b expected sel_a=%0d sel_b=%0d busy_a=0",
                     ifa.pattern_sel, ifb.pattern_sel, ifa.busy, (s0 + 1) % N, (s1 + 2) % N);
        end
    endtask

    task automatic test_reset_mid_fade();
        press();
        for (int g = 0; g < 20 && m_fading[0] && m_t[0] < 10; g++) begin
            run_frame();
            step();
        end
        n_checks++;
        if ({ifa.busy, ifa.rgb} !== {1'b1, exp_rgb(0)} || m_level(0) != 2) begin
            n_fail++;
            $display("FAIL mid_fade_in: got busy=%b rgb=%h expected busy=1 rgb=%h at level 2",
                     ifa.busy, ifa.rgb, exp_rgb(0));
        end
        prgb = {6'h3F, 6'h2A, 6'h15};
        #3;
        rst = 1'b1;
        #1;
        n_checks++;
        if ({ifa.rgb, ifa.pattern_sel, ifa.next_frame, ifa.pattern_rst, ifa.busy} !==
            {6'h15, 2'd0, 3'b000, 3'b111, 1'b0}) begin
            n_fail++;
            $display("FAIL async_reset: got rgb=%h sel=%0d nf=%b prst=%b busy=%b expected rgb=15 sel=0 nf=000 prst=111 busy=0",
                     ifa.rgb, ifa.pattern_sel, ifa.next_frame, ifa.pattern_rst, ifa.busy);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
        for (int j = 0; j < 3; j++) begin
            run_frame();
            step();
            for (int k = 0; k < 2; k++) begin
                n_checks++;
                if (obs(k) !== exp_vec(k)) begin
                    n_fail++; $display("FAIL post_reset dut%0d: got %h expected %h", k, obs(k), exp_vec(k));
                end
            end
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected end of test");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_auto_cycle();
        test_fade_levels();
        test_wrap();
        test_paused();
        test_back_to_back();
        test_reset_mid_fade();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
